// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 4-bit-address RISC core: fetch, decode, execute, memory, write-back.
// Latency: 3 cycles (NOP/JMP/JZ/JNZ/ST/HLT), 4 (LDI/ALU), 5 (LD) with zero fetch wait states.
// Backpressure: FETCH waits for imem_ready; FETCH_TIMEOUT empty cycles raise a sticky fault and halt.
module cpu_sequencer #(
   parameter int ADDR_W        = 4,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [7:0]        instr,
   input  logic              imem_ready,
   input  logic              zero_flag,
   output logic              imem_req,
   output logic              pc_advance,
   output logic              pc_jump,
   output logic [ADDR_W-1:0] pc_target,
   output logic [2:0]        alu_op,
   output logic              alu_src_imm,
   output logic              reg_we,
   output logic              dmem_re,
   output logic              dmem_we,
   output logic              halted,
   output logic              fault,
   output logic [7:0]        retired,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_JNZ = 4'h8;
   localparam logic [3:0] OP_LD  = 4'h9;
   localparam logic [3:0] OP_ST  = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [7:0] TMO_LIM = 8'(FETCH_TIMEOUT);

   state_t     st;
   logic [7:0] ir;
   logic [7:0] tmo;

   assign state     = st;
   assign pc_target = ir[ADDR_W-1:0];

   // Single FSM: every output is registered and set on the edge that enters the state it belongs to,
   // so EXEC strobes are decided on the DECODE->EXEC edge (zero_flag is sampled on that edge).
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= S_IDLE;
         ir          <= 8'h00;
         tmo         <= 8'h00;
         retired     <= 8'h00;
         fault       <= 1'b0;
         halted      <= 1'b0;
         imem_req    <= 1'b0;
         pc_advance  <= 1'b0;
         pc_jump     <= 1'b0;
         reg_we      <= 1'b0;
         dmem_re     <= 1'b0;
         dmem_we     <= 1'b0;
         alu_src_imm <= 1'b0;
         alu_op      <= 3'd0;
      end else begin
         imem_req    <= 1'b0;
         pc_advance  <= 1'b0;
         pc_jump     <= 1'b0;
         reg_we      <= 1'b0;
         dmem_re     <= 1'b0;
         dmem_we     <= 1'b0;
         alu_src_imm <= 1'b0;
         alu_op      <= 3'd0;
         case (st)
            S_IDLE: begin
               if (run) begin
                  st       <= S_FETCH;
                  imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_ready) begin
                  ir  <= instr;
                  tmo <= 8'h00;
                  st  <= S_DECODE;
               end else if (tmo + 8'd1 == TMO_LIM) begin
                  // timeout halt is not a retirement
                  tmo    <= tmo + 8'd1;
                  fault  <= 1'b1;
                  halted <= 1'b1;
                  st     <= S_HALT;
               end else begin
                  tmo      <= tmo + 8'd1;
                  imem_req <= 1'b1;
               end
            end
            S_DECODE: begin
               st <= S_EXEC;
               case (ir[7:4])
                  OP_NOP: pc_advance <= 1'b1;
                  OP_LDI: alu_src_imm <= 1'b1;
                  OP_ADD: alu_op <= 3'd1;
                  OP_SUB: alu_op <= 3'd2;
                  OP_AND: alu_op <= 3'd3;
                  OP_OR:  alu_op <= 3'd4;
                  OP_JMP: pc_jump <= 1'b1;
                  OP_JZ: begin
                     pc_jump    <= zero_flag;
                     pc_advance <= ~zero_flag;
                  end
                  OP_JNZ: begin
                     pc_jump    <= ~zero_flag;
                     pc_advance <= zero_flag;
                  end
                  OP_LD: dmem_re <= 1'b1;
                  OP_ST: begin
                     dmem_we    <= 1'b1;
                     pc_advance <= 1'b1;
                  end
                  OP_HLT: ;
                  default: begin
                     // B..E: flag it, then carry on as a NOP
                     fault      <= 1'b1;
                     pc_advance <= 1'b1;
                  end
               endcase
            end
            S_EXEC: begin
               case (ir[7:4])
                  OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     st         <= S_WB;
                     reg_we     <= 1'b1;
                     pc_advance <= 1'b1;
                  end
                  OP_LD: st <= S_MEM;
                  OP_HLT: begin
                     st      <= S_HALT;
                     halted  <= 1'b1;
                     retired <= retired + 8'd1;
                  end
                  default: begin
                     st       <= S_FETCH;
                     imem_req <= 1'b1;
                     retired  <= retired + 8'd1;
                  end
               endcase
            end
            S_MEM: begin
               st         <= S_WB;
               reg_we     <= 1'b1;
               pc_advance <= 1'b1;
            end
            S_WB: begin
               st       <= S_FETCH;
               imem_req <= 1'b1;
               retired  <= retired + 8'd1;
            end
            S_HALT: halted <= 1'b1;
            default: begin
               // encoding 7 cannot be reached legally; park safely
               st     <= S_HALT;
               fault  <= 1'b1;
               halted <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, randomized instructions against a rule model.
// Latency: each instruction is run to the next FETCH (or HALT) and its strobes are tallied per instruction.
// Backpressure: random fetch wait states are inserted below the timeout; a dedicated sequence provokes the timeout.
module tb_cpu_sequencer;

   localparam int FETCH_TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst, run, imem_ready, zero_flag;
   logic [7:0] instr;
   logic       imem_req, pc_advance, pc_jump, alu_src_imm, reg_we, dmem_re, dmem_we, halted, fault;
   logic [3:0] pc_target;
   logic [2:0] alu_op, state;
   logic [7:0] retired;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   cpu_sequencer #(.ADDR_W(4), .FETCH_TIMEOUT(FETCH_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .run(run), .instr(instr), .imem_ready(imem_ready), .zero_flag(zero_flag),
      .imem_req(imem_req), .pc_advance(pc_advance), .pc_jump(pc_jump), .pc_target(pc_target),
      .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_we(reg_we), .dmem_re(dmem_re), .dmem_we(dmem_we),
      .halted(halted), .fault(fault), .retired(retired), .state(state)
   );

   typedef struct {
      int cyc, adv, jmp, we, re, wr, aluop, imm;
   } exp_t;

   typedef struct {
      logic [7:0] ins;
      logic       zf;
      exp_t       e;
   } vec_t;

   typedef struct {
      int cyc, adv, jmp, we, re, wr, aluop, imm, tgt, both, req, wait_bad, done, ret, flt, hlt;
      logic [2:0] st_end;
   } obs_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // What an instruction must do, stated directly from the ISA rules.
   function automatic exp_t model(input logic [7:0] ins, input logic zf);
      exp_t e;
      int op;
      op = int'(ins[7:4]);
      e.cyc   = (op == 9) ? 5 : (op >= 1 && op <= 5) ? 4 : 3;
      e.jmp   = (op == 6 || (op == 7 && zf) || (op == 8 && !zf)) ? 1 : 0;
      e.adv   = (op == 15 || e.jmp == 1) ? 0 : 1;
      e.we    = ((op >= 1 && op <= 5) || op == 9) ? 1 : 0;
      e.re    = (op == 9) ? 1 : 0;
      e.wr    = (op == 10) ? 1 : 0;
      e.aluop = (op >= 2 && op <= 5) ? op - 1 : 0;
      e.imm   = (op == 1) ? 1 : 0;
      return e;
   endfunction

   // Start at a negedge in FETCH; run one instruction until the FSM is back in FETCH or in HALT.
   task automatic run_instr(input logic [7:0] ins, input logic zf, input int waits, output obs_t o);
      o = '{default: 0};
      instr = ins;
      zero_flag = zf;
      imem_ready = 1'b0;
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         if (state != 3'd1 || imem_req != 1'b1) o.wait_bad++;
      end
      imem_ready = 1'b1;
      o.cyc = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         imem_ready = 1'b0;
         if (state == 3'd1 || state == 3'd6) begin
            o.done = 1;
            break;
         end
         o.cyc++;
         o.adv += int'(pc_advance);
         o.jmp += int'(pc_jump);
         o.we  += int'(reg_we);
         o.re  += int'(dmem_re);
         o.wr  += int'(dmem_we);
         o.req += int'(imem_req);
         if (pc_advance && pc_jump) o.both++;
         if (state == 3'd3) begin
            o.aluop = int'(alu_op);
            o.imm   = int'(alu_src_imm);
            o.tgt   = int'(pc_target);
         end
      end
      o.st_end = state;
      o.ret    = int'(retired);
      o.flt    = int'(fault);
      o.hlt    = int'(halted);
      chk("instr_done", o.done, 1);
   endtask

   task automatic check_obs(input obs_t o, input exp_t e, input logic [7:0] ins, input int exp_ret);
      chk("cycles", o.cyc, e.cyc);
      chk("pc_advance", o.adv, e.adv);
      chk("pc_jump", o.jmp, e.jmp);
      chk("reg_we", o.we, e.we);
      chk("dmem_re", o.re, e.re);
      chk("dmem_we", o.wr, e.wr);
      chk("alu_op", o.aluop, e.aluop);
      chk("alu_src_imm", o.imm, e.imm);
      chk("pc_target", o.tgt, int'(ins[3:0]));
      chk("adv_jmp_excl", o.both, 0);
      chk("req_outside_fetch", o.req + o.wait_bad, 0);
      chk("retired", o.ret, exp_ret);
   endtask

   // Reset, release, run=1; returns at a negedge in FETCH.
   task automatic reset_and_start();
      rst = 1'b1;
      run = 1'b1;
      imem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[13];
      obs_t o;
      exp_t e;
      int   ret_model;
      int   exp_fault;
      int   cnt;
      logic [7:0] ins;
      logic zf;

      vt[0]  = '{8'h00, 1'b0, '{3, 1, 0, 0, 0, 0, 0, 0}};
      vt[1]  = '{8'h15, 1'b0, '{4, 1, 0, 1, 0, 0, 0, 1}};
      vt[2]  = '{8'h25, 1'b0, '{4, 1, 0, 1, 0, 0, 1, 0}};
      vt[3]  = '{8'h33, 1'b1, '{4, 1, 0, 1, 0, 0, 2, 0}};
      vt[4]  = '{8'h44, 1'b0, '{4, 1, 0, 1, 0, 0, 3, 0}};
      vt[5]  = '{8'h5E, 1'b0, '{4, 1, 0, 1, 0, 0, 4, 0}};
      vt[6]  = '{8'h7A, 1'b1, '{3, 0, 1, 0, 0, 0, 0, 0}};
      vt[7]  = '{8'h7A, 1'b0, '{3, 1, 0, 0, 0, 0, 0, 0}};
      vt[8]  = '{8'h8B, 1'b0, '{3, 0, 1, 0, 0, 0, 0, 0}};
      vt[9]  = '{8'h8B, 1'b1, '{3, 1, 0, 0, 0, 0, 0, 0}};
      vt[10] = '{8'h63, 1'b0, '{3, 0, 1, 0, 0, 0, 0, 0}};
      vt[11] = '{8'h96, 1'b0, '{5, 1, 0, 1, 1, 0, 0, 0}};
      vt[12] = '{8'hA7, 1'b0, '{3, 1, 0, 0, 0, 1, 0, 0}};

      // reset state
      rst = 1'b1; run = 1'b0; instr = 8'h00; imem_ready = 1'b0; zero_flag = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", int'(state), 0);
      chk("rst_strobes", int'({imem_req, pc_advance, pc_jump, reg_we, dmem_re, dmem_we, alu_src_imm}), 0);
      chk("rst_alu_op", int'(alu_op), 0);
      chk("rst_status", int'({halted, fault}), 0);
      chk("rst_retired", int'(retired), 0);

      // first NOP, cycle by cycle
      rst = 1'b0;
      run = 1'b1;
      @(negedge clk);
      chk("trace_fetch", int'({state, imem_req}), int'({3'd1, 1'b1}));
      imem_ready = 1'b1;
      @(negedge clk);
      chk("trace_decode", int'(state), 2);
      @(negedge clk);
      chk("trace_exec", int'({state, pc_advance}), int'({3'd3, 1'b1}));
      @(negedge clk);
      imem_ready = 1'b0;
      chk("trace_refetch", int'(state), 1);
      chk("trace_retired", int'(retired), 1);
      ret_model = 1;

      // directed vector table
      for (int i = 0; i < 13; i++) begin
         run_instr(vt[i].ins, vt[i].zf, i % 3, o);
         ret_model = (ret_model + 1) % 256;
         check_obs(o, vt[i].e, vt[i].ins, ret_model);
         chk("vec_end_fetch", int'(o.st_end), 1);
      end

      // randomized instructions against the rule model (no HLT here)
      exp_fault = 0;
      for (int i = 0; i < 80; i++) begin
         ins = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
         zf  = 1'($urandom_range(0, 1));
         e   = model(ins, zf);
         run_instr(ins, zf, $urandom_range(0, 4), o);
         ret_model = (ret_model + 1) % 256;
         if (ins[7:4] >= 4'hB) exp_fault = 1;
         check_obs(o, e, ins, ret_model);
         chk("rnd_fault", o.flt, exp_fault);
      end

      // illegal opcode then HLT; run is ignored once halted
      reset_and_start();
      run_instr(8'hC3, 1'b0, 0, o);
      chk("illegal_fault", o.flt, 1);
      chk("illegal_adv", o.adv, 1);
      chk("illegal_continues", int'(o.st_end), 1);
      chk("illegal_retired", o.ret, 1);
      run_instr(8'hF0, 1'b0, 0, o);
      chk("hlt_state", int'(o.st_end), 6);
      chk("hlt_halted", o.hlt, 1);
      chk("hlt_cycles", o.cyc, 3);
      chk("hlt_pc_pulses", o.adv + o.jmp, 0);
      chk("hlt_retired", o.ret, 2);
      imem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run = ~run;
         @(negedge clk);
      end
      chk("halt_sticky", int'({state, halted, imem_req}), int'({3'd6, 1'b1, 1'b0}));

      // fetch timeout
      reset_and_start();
      imem_ready = 1'b0;
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (state == 3'd1) cnt++;
         else break;
      end
      chk("tmo_fetch_cycles", cnt, FETCH_TIMEOUT);
      chk("tmo_state", int'(state), 6);
      chk("tmo_fault_halted", int'({fault, halted}), 3);
      chk("tmo_retired", int'(retired), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("tmo_rst_state", int'(state), 0);
      chk("tmo_rst_fault", int'({fault, halted}), 0);

      // reset while an LD is in WB
      reset_and_start();
      run_instr(8'h00, 1'b0, 0, o);
      chk("ld_pre_retired", o.ret, 1);
      instr = 8'h96;
      imem_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         imem_ready = 1'b0;
         if (state == 3'd5) break;
         cnt++;
      end
      chk("ld_reach_wb", int'({state, reg_we}), int'({3'd5, 1'b1}));
      chk("ld_wb_offset", cnt, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("ld_rst_state", int'(state), 0);
      chk("ld_rst_reg_we", int'(reg_we), 0);
      chk("ld_rst_retired", int'(retired), 0);

      // 256 NOPs wrap the retired counter
      reset_and_start();
      for (int i = 1; i <= 256; i++) begin
         run_instr(8'h00, 1'b0, 0, o);
         if (i == 255) chk("wrap_255", o.ret, 255);
      end
      chk("wrap_0", o.ret, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
